// File: rtl/maze_pkg.sv
// Shared maze definitions: geometry, tile codes, mover direction encoding,
// wall-server FSM states and the tile classification rule.
package maze_pkg;

    localparam int MAP_W    = 28;
    localparam int MAP_H    = 36;
    localparam int TUNNEL_Y = 19;

    localparam logic [1:0] TILE_PATH = 2'b00;
    localparam logic [1:0] TILE_WALL = 2'b01;
    localparam logic [1:0] TILE_DOOR = 2'b10;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_LATCH,
        ST_RD_U,
        ST_RD_D,
        ST_RD_L,
        ST_RD_R,
        ST_COMMIT
    } state_t;

    // Code 11 is treated as wall; a door blocks only agents without door passage.
    function automatic logic tile_blocked(input logic [1:0] code, input logic pass);
        logic blk;
        case (code)
            TILE_PATH: blk = 1'b0;
            TILE_DOOR: blk = ~pass;
            default:   blk = 1'b1;
        endcase
        return blk;
    endfunction

endpackage

// File: rtl/maze_addr_calc.sv
// Neighbour tile address for (x, y, dir) with edge handling and tunnel wrap.
// Out-of-range neighbours (or an off-map origin) give oor = 1 and addr = 0.
module maze_addr_calc import maze_pkg::*; #(
    parameter int W  = MAP_W,
    parameter int H  = MAP_H,
    parameter int TY = TUNNEL_Y
) (
    input  logic [5:0] x,
    input  logic [5:0] y,
    input  logic [1:0] dir,
    output logic [9:0] addr,
    output logic       oor
);

    logic [5:0] nx;
    logic [5:0] ny;

    always_comb begin
        nx  = x;
        ny  = y;
        oor = 1'b0;
        if (x >= 6'(W) || y >= 6'(H)) begin
            oor = 1'b1;
        end else begin
            case (dir)
                DIR_UP: begin
                    if (y == 6'd0) oor = 1'b1;
                    else           ny  = y - 6'd1;
                end
                DIR_DOWN: begin
                    if (y == 6'(H - 1)) oor = 1'b1;
                    else                ny  = y + 6'd1;
                end
                DIR_LEFT: begin
                    if (x != 6'd0)          nx  = x - 6'd1;
                    else if (y == 6'(TY))   nx  = 6'(W - 1);
                    else                    oor = 1'b1;
                end
                default: begin
                    if (x != 6'(W - 1))     nx  = x + 6'd1;
                    else if (y == 6'(TY))   nx  = 6'd0;
                    else                    oor = 1'b1;
                end
            endcase
        end
        addr = oor ? 10'd0 : (10'(ny) * 10'(W)) + 10'(nx);
    end

endmodule

// File: rtl/maze_wall_server.sv
// Round-robin wall-flag server: reads the four neighbour tiles of each agent
// from the shared maze ROM and publishes registered per-agent wall flags.
module maze_wall_server #(
    parameter int NUM_AGENTS = 5,
    parameter int MAP_W      = maze_pkg::MAP_W,
    parameter int MAP_H      = maze_pkg::MAP_H,
    parameter int TUNNEL_Y   = maze_pkg::TUNNEL_Y
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6*NUM_AGENTS-1:0] agentX,
    input  logic [6*NUM_AGENTS-1:0] agentY,
    input  logic [NUM_AGENTS-1:0]   doorPass,
    output logic [9:0]              romAddr,
    input  logic [1:0]              romData,
    output logic [NUM_AGENTS-1:0]   wallUp,
    output logic [NUM_AGENTS-1:0]   wallDown,
    output logic [NUM_AGENTS-1:0]   wallLeft,
    output logic [NUM_AGENTS-1:0]   wallRight,
    output logic [NUM_AGENTS-1:0]   flagValid,
    output logic                    scanDone
);
    import maze_pkg::*;

    localparam int IW = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;

    state_t        state_reg;
    logic [IW-1:0] idx_reg;
    logic [5:0]    cur_x_reg;
    logic [5:0]    cur_y_reg;
    logic          cur_pass_reg;
    logic [9:0]    rom_addr_reg;
    logic          oor_reg;
    logic          oor_d_reg;
    logic          blk_u_reg;
    logic          blk_d_reg;
    logic          blk_l_reg;
    logic          scan_done_reg;

    logic [5:0]    sel_x;
    logic [5:0]    sel_y;
    logic [5:0]    calc_x;
    logic [5:0]    calc_y;
    dir_t          calc_dir;
    logic          calc_en;
    logic [9:0]    calc_addr;
    logic          calc_oor;
    logic          data_blk;
    logic          commit;

    assign sel_x = agentX[6*idx_reg +: 6];
    assign sel_y = agentY[6*idx_reg +: 6];

    // The address is registered one state ahead, so LATCH already computes the
    // up address from the live inputs that are being latched on the same edge.
    always_comb begin
        calc_en  = 1'b1;
        calc_dir = DIR_UP;
        calc_x   = cur_x_reg;
        calc_y   = cur_y_reg;
        case (state_reg)
            ST_LATCH: begin
                calc_x = sel_x;
                calc_y = sel_y;
            end
            ST_RD_U: calc_dir = DIR_DOWN;
            ST_RD_D: calc_dir = DIR_LEFT;
            ST_RD_L: calc_dir = DIR_RIGHT;
            default: calc_en  = 1'b0;
        endcase
    end

    maze_addr_calc #(
        .W  (MAP_W),
        .H  (MAP_H),
        .TY (TUNNEL_Y)
    ) u_addr_calc (
        .x    (calc_x),
        .y    (calc_y),
        .dir  (calc_dir),
        .addr (calc_addr),
        .oor  (calc_oor)
    );

    // oor_d_reg lines up with romData: both describe the read issued last cycle.
    assign data_blk = oor_d_reg | tile_blocked(romData, cur_pass_reg);
    assign commit   = (state_reg == ST_COMMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_LATCH;
            idx_reg       <= '0;
            cur_x_reg     <= '0;
            cur_y_reg     <= '0;
            cur_pass_reg  <= 1'b0;
            rom_addr_reg  <= '0;
            oor_reg       <= 1'b1;
            oor_d_reg     <= 1'b1;
            blk_u_reg     <= 1'b1;
            blk_d_reg     <= 1'b1;
            blk_l_reg     <= 1'b1;
            scan_done_reg <= 1'b0;
        end else begin
            rom_addr_reg  <= calc_en ? calc_addr : 10'd0;
            oor_reg       <= calc_en ? calc_oor : 1'b1;
            oor_d_reg     <= oor_reg;
            scan_done_reg <= 1'b0;
            case (state_reg)
                ST_LATCH: begin
                    cur_x_reg    <= sel_x;
                    cur_y_reg    <= sel_y;
                    cur_pass_reg <= doorPass[idx_reg];
                    state_reg    <= ST_RD_U;
                end
                ST_RD_U: state_reg <= ST_RD_D;
                ST_RD_D: begin
                    blk_u_reg <= data_blk;
                    state_reg <= ST_RD_L;
                end
                ST_RD_L: begin
                    blk_d_reg <= data_blk;
                    state_reg <= ST_RD_R;
                end
                ST_RD_R: begin
                    blk_l_reg <= data_blk;
                    state_reg <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    scan_done_reg <= (idx_reg == IW'(NUM_AGENTS - 1));
                    idx_reg       <= (idx_reg == IW'(NUM_AGENTS - 1)) ? '0 : idx_reg + 1'b1;
                    state_reg     <= ST_LATCH;
                end
                default: state_reg <= ST_LATCH;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AGENTS; gi++) begin : g_agent
            logic       up_reg;
            logic       down_reg;
            logic       left_reg;
            logic       right_reg;
            logic       valid_reg;
            logic [5:0] cmt_x_reg;
            logic [5:0] cmt_y_reg;
            logic       hit;

            assign hit = commit && (idx_reg == IW'(gi));

            // A commit takes priority over a staleness detection on the same edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    up_reg    <= 1'b1;
                    down_reg  <= 1'b1;
                    left_reg  <= 1'b1;
                    right_reg <= 1'b1;
                    valid_reg <= 1'b0;
                    cmt_x_reg <= '0;
                    cmt_y_reg <= '0;
                end else if (hit) begin
                    up_reg    <= blk_u_reg;
                    down_reg  <= blk_d_reg;
                    left_reg  <= blk_l_reg;
                    right_reg <= data_blk;
                    valid_reg <= 1'b1;
                    cmt_x_reg <= cur_x_reg;
                    cmt_y_reg <= cur_y_reg;
                end else if (agentX[6*gi +: 6] != cmt_x_reg || agentY[6*gi +: 6] != cmt_y_reg) begin
                    valid_reg <= 1'b0;
                end
            end

            assign wallUp[gi]    = up_reg;
            assign wallDown[gi]  = down_reg;
            assign wallLeft[gi]  = left_reg;
            assign wallRight[gi] = right_reg;
            assign flagValid[gi] = valid_reg;
        end
    endgenerate

    assign romAddr  = rom_addr_reg;
    assign scanDone = scan_done_reg;

endmodule

// File: doc/maze_wall_server.md
# maze_wall_server

Supplies the per-agent wall flags (`wallUp/Down/Left/Right`) that the ghost and Pac-Man movement blocks consume. It continuously round-robins over all agents, reads the four neighbour tiles of each agent's current tile from the shared maze tile ROM, and publishes registered flags. It also applies the tunnel wrap and the ghost-house door rule. It sits between the maze ROM and the movers, alongside the move-tick logic.

## Interface
- `NUM_AGENTS`, 5: number of movers served. Index 0 is Pac-Man; indices 1–4 are the ghosts.
- `MAP_W`, 28: maze width in tiles.
- `MAP_H`, 36: maze height in tiles.
- `TUNNEL_Y`, 19: row on which the left and right edges wrap.
- `clk` in 1: system clock, 25 MHz.
- `reset` in 1: reset; one clock, synchronous, active-high.
- `agentX` in 6*NUM_AGENTS: packed tile X coordinates; agent i occupies bits [6i+5:6i].
- `agentY` in 6*NUM_AGENTS: packed tile Y coordinates, same packing as `agentX`.
- `doorPass` in NUM_AGENTS: 1 means the agent may pass door tiles.
- `romAddr` out 10: tile address, computed as y*MAP_W + x.
- `romData` in 2: tile code, valid exactly 1 cycle after `romAddr`. Codes: 00 = path, 01 = wall, 10 = door, 11 = wall.
- `wallUp`, `wallDown`, `wallLeft`, `wallRight` out NUM_AGENTS each: registered flags; 1 means blocked.
- `flagValid` out NUM_AGENTS: 1 means the stored flags correspond to the agent's current position.
- `scanDone` out 1: one-cycle pulse after agent NUM_AGENTS-1 commits.

## Operation
- **FSM states:** LATCH → RD_U → RD_D → RD_L → RD_R → COMMIT → LATCH. The machine runs forever with no idle state.
- **LATCH:** sample `agentX[idx]`, `agentY[idx]` and `doorPass[idx]` into `curX/curY/curPass`.
- **RD_* states:** drive `romAddr` for the neighbour tile in that direction.
  - Up neighbour is (x, y-1); down is (x, y+1); left is (x-1, y); right is (x+1, y).
  - Data for each read arrives in the next state and is classified into a per-direction blocked bit.
- **COMMIT:**
  - Classify the R data.
  - Write all four flags for `idx` atomically, set `flagValid[idx]`, and store `curX/curY` as `cmtX[idx]/cmtY[idx]`.
  - Advance `idx`, wrapping from NUM_AGENTS-1 to 0.
- **Classification:**
  - Path → 0.
  - Wall or 11 → 1.
  - Door → `~curPass`.
- **Boundaries:** out-of-range neighbours issue no meaningful read (`romAddr` is 0, data ignored) and resolve to 1.
  - Up with y = 0 → 1.
  - Down with y = MAP_H-1 → 1.
  - Left with x = 0: if y = TUNNEL_Y, read (MAP_W-1, y); otherwise 1.
  - Right with x = MAP_W-1: if y = TUNNEL_Y, read (0, y); otherwise 1.
- **Invalid latched position** (x ≥ MAP_W or y ≥ MAP_H): all four flags resolve to 1, and the commit still sets `flagValid`.
- **Staleness:**
  - `flagValid[i]` clears on the first cycle that `agentX/Y[i]` differs from `cmtX/cmtY[i]`. This check is registered with 1 cycle of latency.
  - Flags themselves are not cleared; they hold their last committed values.
  - If COMMIT for agent i coincides with a staleness detection for i, the commit wins. The next cycle's comparison then uses the new `cmt` values.
- **Address arithmetic:** y*28 = (y<<4)+(y<<3)+(y<<2), evaluated in 10 bits; the maximum address is 1007.

## Timing
- **Reset values:**
  - `wallUp/Down/Left/Right` = all 1s, which blocks every mover.
  - `flagValid` = 0, `scanDone` = 0, `romAddr` = 0.
  - State = LATCH, `idx` = 0.
- **Per agent:** 6 cycles; a full sweep takes 6*NUM_AGENTS = 30 cycles.
- **Latency bound:** a position change is reflected in valid flags within ≤ 6*NUM_AGENTS+6 cycles, which is far below one move tick (416,667 cycles).
- **First outputs:** agent 0's flags commit on cycle 6 after reset deasserts. `scanDone` first pulses on cycle 30.
- **Reset mid-scan:** aborts the scan with no partial commit; all outputs return to their reset values on the next edge.
- **Input stability:** inputs are sampled only in LATCH. A position change during RD_* does not affect the in-flight commit, but it does clear `flagValid` afterwards.

## Structure
- **Shared package `maze_pkg`:**
  - Tile codes TILE_PATH, TILE_WALL, TILE_DOOR.
  - MAP_W, MAP_H, TUNNEL_Y.
  - Direction encoding: 0 = up, 1 = down, 2 = left, 3 = right, matching the movers.
  - FSM state enum.
- **Sub-module `maze_addr_calc`:** combinational; computes the neighbour address plus an out-of-range flag from (x, y, dir), including the tunnel wrap.
- **ROM:** the maze ROM itself is external and shared with the renderer.

## Test plan
- **Reset:** hold `reset` 3 cycles → all wall outputs = 1, `flagValid` = 0, `romAddr` = 0. After release, agent 0 commits at cycle 6 and `scanDone` pulses at cycle 30.
- **Open tile:** agent 0 at (6,5) with a ROM model giving path at (6,4) and (6,6) and wall at (5,5) and (7,5) → committed flags are up = 0, down = 0, left = 1, right = 1.
- **Tunnel wrap:** agent 2 at (0,19) with path at (27,19) → left read address = 19*28+27 = 559, `wallLeft[2]` = 0. Agent 2 at (0,18) → `wallLeft[2]` = 1 with no read.
- **Door rule:** agent 4 at (13,17), tile (13,16) = door:
  - `doorPass[4]` = 1 → `wallUp[4]` = 0.
  - `doorPass[4]` = 0 → `wallUp[4]` = 1.
- **Staleness:** move agent 1 from (6,5) to (7,5) → `flagValid[1]` = 0 one cycle later and returns to 1 within 36 cycles with the new flags.
- **Bad coordinates and reset mid-scan:**
  - Agent 3 at (40,50) → all four flags = 1, valid = 1.
  - Assert `reset` during RD_L → no commit, and the outputs return to their reset values.
